frame_dma_ctrl: RTL
===================

// Module: frame_dma_ctrl
// PURPOSE
//  Transaction sequencer directly upstream of the AHB master interface.
//  - On start, fetches num_words words from src_base through the AHB master (re/read_complete).
//  - Hands each fetched greyscale word to the edge-detection datapath (pix_valid/pix_ready).
//  - Writes each returned result word to dst_base (we/write_complete).
//  - Exactly one AHB transaction outstanding at any time.
// PARAMETERS
//  ADDR_W     32  AHB address width
//  DATA_W     32  data word width
//  CNT_W      16  width of num_words and internal word counters
//  ADDR_STEP  4   byte increment between consecutive words
// PORTS
//  clk             in   1       system clock, rising edge
//  rst             in   1       asynchronous, active-high reset
//  start           in   1       begin transfer; sampled only in IDLE
//  src_base        in   ADDR_W  first read address; latched on start
//  dst_base        in   ADDR_W  first write address; latched on start
//  num_words       in   CNT_W   words to read and to write; latched on start
//  re              out  1       one-cycle read request pulse to AHB master
//  we              out  1       one-cycle write request pulse to AHB master
//  mcu_raddr       out  ADDR_W  read address; stable from re until read_complete
//  mcu_waddr       out  ADDR_W  write address; stable from we until write_complete
//  buffer2_data    out  DATA_W  write data; stable from we until write_complete
//  read_complete   in   1       AHB master: read finished, greyscale_data valid this cycle
//  write_complete  in   1       AHB master: write finished
//  greyscale_data  in   DATA_W  read data from AHB master
//  pix_data        out  DATA_W  fetched word to datapath
//  pix_valid       out  1       pix_data valid; held until pix_ready
//  pix_ready       in   1       datapath accepts pix_data
//  res_data        in   DATA_W  result word from datapath
//  res_valid       in   1       res_data valid
//  res_ready       out  1       one-cycle pulse when res_data is captured
//  busy            out  1       high from the cycle after start until done
//  done            out  1       one-cycle pulse when the transfer ends
// BEHAVIOUR
//  - Reset values: every output 0; state IDLE; counters, address and data registers cleared.
//  - Reset is honoured mid-transfer: an outstanding request is abandoned; later completes land in IDLE and are ignored.
//  - States: IDLE, ARB, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
//  - IDLE: when start=1, latch bases and num_words, clear rd_cnt and wr_cnt, go to ARB next cycle. Otherwise start is ignored.
//  - ARB, priority order:
//    1. wr_cnt==num_words and rd_cnt==num_words -> FIN.
//    2. res_valid and wr_cnt<num_words -> capture res_data into buffer2_data, pulse res_ready, go to WR_REQ.
//    3. rd_cnt<num_words and !pix_valid -> RD_REQ.
//    4. Otherwise stay in ARB.
//  - Writes take priority over reads, so the datapath can always drain.
//  - RD_REQ: re=1 for exactly one cycle with mcu_raddr=src_base+rd_cnt*ADDR_STEP, then RD_WAIT.
//  - RD_WAIT: on read_complete, pix_data<=greyscale_data, pix_valid<=1, rd_cnt++, then ARB.
//  - WR_REQ: we=1 for exactly one cycle with mcu_waddr=dst_base+wr_cnt*ADDR_STEP, then WR_WAIT.
//  - WR_WAIT: on write_complete, wr_cnt++, then ARB.
//  - pix_valid clears in the cycle after pix_valid&pix_ready. It is independent of the FSM (hold register).
//  - FIN: done=1 for one cycle, busy=0, then IDLE. busy is high in every state except IDLE and FIN.
//  - Latency: re asserts 2 cycles after start. Minimum read turn-around is ARB->RD_REQ->RD_WAIT->complete.
//  - read_complete outside RD_WAIT, or write_complete outside WR_WAIT, is ignored. If both are high together, only the one matching the current state counts.
//  - num_words=0: ARB goes straight to FIN; done pulses 2 cycles after start; re and we never assert.
//  - Address arithmetic is modulo 2^ADDR_W, so addresses wrap silently. Counters are CNT_W bits and never exceed num_words.
//  - re and we are never high in the same cycle.
// STRUCTURE
//  - Package edge_dma_pkg holds:
//    - the state enum dma_state_t;
//    - the default ADDR_STEP, ADDR_W, DATA_W, CNT_W localparams.
//  - One sub-module, pix_hold_reg: single-entry valid/ready holding register (pix_data/pix_valid).
//  - FSM, counters and address generation stay in frame_dma_ctrl.
// TESTING
//  1. start, src_base=0x100, dst_base=0x200, num_words=4, pix_ready=1, datapath echoes after 1 cycle,
//     completes 3 cycles after each re/we
//     -> mcu_raddr 0x100,0x104,0x108,0x10C; mcu_waddr 0x200..0x20C; buffer2_data matches;
//        one done pulse; busy falls with done.
//  2. num_words=0 -> done 2 cycles after start; re and we never asserted.
//  3. pix_ready=0 for 10 cycles after the first read
//     -> pix_valid held with data 0xAAAAAAAA; no second re until accepted.
//  4. res_valid high while the pixel register is empty
//     -> the write is issued before the next read; re and we never coincident.
//  5. read_complete+write_complete pulsed in IDLE and during RD_WAIT -> counters change only on the matching complete.
//  6. rst asserted during RD_WAIT, then a late read_complete
//     -> all outputs 0, state IDLE, no pix_valid; a new start runs cleanly.

Source files
------------

// File: rtl/edge_dma_pkg.sv
// Shared types and default geometry for the frame DMA sequencer.
package edge_dma_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned ADDR_STEP = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    FIN
  } dma_state_t;

endpackage

// File: rtl/pix_hold_reg.sv
// Single-entry valid/ready holding register feeding fetched words to the datapath.
module pix_hold_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // load only happens while empty, so it never races the clearing handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_dma_ctrl.sv
// Read/process/write sequencer in front of the AHB master; one bus transaction in flight.
module frame_dma_ctrl
  import edge_dma_pkg::*;
#(
  parameter int unsigned ADDR_W    = edge_dma_pkg::ADDR_W,
  parameter int unsigned DATA_W    = edge_dma_pkg::DATA_W,
  parameter int unsigned CNT_W     = edge_dma_pkg::CNT_W,
  parameter int unsigned ADDR_STEP = edge_dma_pkg::ADDR_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  num_words,
  output logic              re,
  output logic              we,
  output logic [ADDR_W-1:0] mcu_raddr,
  output logic [ADDR_W-1:0] mcu_waddr,
  output logic [DATA_W-1:0] buffer2_data,
  input  logic              read_complete,
  input  logic              write_complete,
  input  logic [DATA_W-1:0] greyscale_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_valid,
  output logic              res_ready,
  output logic              busy,
  output logic              done
);

  dma_state_t        state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [CNT_W-1:0]  num_q, rd_cnt, wr_cnt;
  logic              rd_left, wr_left, all_done;
  logic              pix_load, res_take, rd_go;

  assign rd_left  = (rd_cnt < num_q);
  assign wr_left  = (wr_cnt < num_q);
  assign all_done = (rd_cnt == num_q) && (wr_cnt == num_q);

  always_comb begin
    state_nxt = state;
    pix_load  = 1'b0;
    res_take  = 1'b0;
    rd_go     = 1'b0;
    unique case (state)
      IDLE:    if (start) state_nxt = ARB;
      ARB: begin
        // writes win over reads so the datapath can always drain
        if (all_done) begin
          state_nxt = FIN;
        end else if (res_valid && wr_left) begin
          res_take  = 1'b1;
          state_nxt = WR_REQ;
        end else if (rd_left && !pix_valid) begin
          rd_go     = 1'b1;
          state_nxt = RD_REQ;
        end
      end
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (read_complete) begin
          pix_load  = 1'b1;
          state_nxt = ARB;
        end
      end
      WR_REQ:  state_nxt = WR_WAIT;
      WR_WAIT: if (write_complete) state_nxt = ARB;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign re        = (state == RD_REQ);
  assign we        = (state == WR_REQ);
  assign res_ready = res_take;
  assign busy      = (state != IDLE) && (state != FIN);
  assign done      = (state == FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      num_q        <= '0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      mcu_raddr    <= '0;
      mcu_waddr    <= '0;
      buffer2_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        src_q  <= src_base;
        dst_q  <= dst_base;
        num_q  <= num_words;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end
      // addresses are registered on the ARB decision so they hold through the wait state
      if (rd_go)
        mcu_raddr <= src_q + ADDR_W'(rd_cnt) * ADDR_W'(ADDR_STEP);
      if (res_take) begin
        mcu_waddr    <= dst_q + ADDR_W'(wr_cnt) * ADDR_W'(ADDR_STEP);
        buffer2_data <= res_data;
      end
      if (state == RD_WAIT && read_complete)
        rd_cnt <= rd_cnt + 1'b1;
      if (state == WR_WAIT && write_complete)
        wr_cnt <= wr_cnt + 1'b1;
    end
  end

  pix_hold_reg #(
    .DATA_W (DATA_W)
  ) u_pix_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (pix_load),
    .load_data (greyscale_data),
    .ready     (pix_ready),
    .valid     (pix_valid),
    .data      (pix_data)
  );

endmodule
